// File: rtl/add_share_pkg.sv
// Shared definitions for the add_share_arbiter slice.
// Holds default sizing, the output-slot state encoding and the
// operand slice width used to unpack the requester operand buses.
package add_share_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 32;
  localparam int IDW_DEF   = 2;

  // Each requester owns one WIDTH-bit slice of the packed operand buses.
  localparam int SLICE_W = WIDTH_DEF;

  // The result register is either empty or holding a result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: searches req upward starting at ptr,
// wrapping from NREQ-1 back to 0, and returns the first set bit both
// as a one-hot grant and as an encoded index. Purely combinational so
// other shared units can reuse it with their own pointer register.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [IDW:0]   pos_wide;
  logic [IDW-1:0] pos;
  logic           found;

  // Walk the candidates in priority order; the first valid one wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    pos_wide = '0;
    pos      = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_wide = {1'b0, ptr} + (IDW+1)'(k);
      if (pos_wide >= (IDW+1)'(NREQ)) begin
        pos_wide = pos_wide - (IDW+1)'(NREQ);
      end
      pos = pos_wide[IDW-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one adder among NREQ requesters with round-robin arbitration.
// The winning a + b is captured with the winner's index in a single
// result register that drains through a valid/ready response port.
// Optional feature: define ADD_SHARE_ARBITER_CARRY_EN to add the
// registered carry-out port resp_cout.
module add_share_arbiter
  import add_share_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = SLICE_W,
  parameter int IDW   = IDW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_sum
`ifdef ADD_SHARE_ARBITER_CARRY_EN
  ,
  output logic                  resp_cout
`endif
);

  slot_state_t      state;
  slot_state_t      state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_ptr_next;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             can_accept;
  logic             transfer;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
`ifdef ADD_SHARE_ARBITER_CARRY_EN
  logic [WIDTH:0]   sum_full;
`else
  logic [WIDTH-1:0] sum_full;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  assign resp_valid = (state == ST_FULL);

  // The slot can take a new result when empty or when it drains this cycle.
  always_comb begin
    can_accept = (state == ST_EMPTY) || resp_ready;
    req_ready  = '0;
    if (rst_n && can_accept) begin
      req_ready = grant;
    end
    transfer = |req_ready;
  end

  // Select the winner's operands and form the shared sum.
  always_comb begin
    a_sel = req_a[win_idx*WIDTH +: WIDTH];
    b_sel = req_b[win_idx*WIDTH +: WIDTH];
`ifdef ADD_SHARE_ARBITER_CARRY_EN
    sum_full = {1'b0, a_sel} + {1'b0, b_sel};
`else
    sum_full = a_sel + b_sel;
`endif
  end

  // Pointer moves to the slot just past the winner so it gets lowest priority next.
  always_comb begin
    rr_ptr_next = rr_ptr;
    if (transfer) begin
      if (win_idx == IDW'(NREQ-1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = win_idx + 1'b1;
      end
    end
  end

  // Slot fills on a transfer and empties on a drain with no refill.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (transfer) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (resp_ready && !transfer) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Slot state and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Result register only loads on a transfer, so it holds through stalls and drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_sum <= '0;
      resp_id  <= '0;
    end else if (transfer) begin
      resp_sum <= sum_full[WIDTH-1:0];
      resp_id  <= win_idx;
    end
  end

`ifdef ADD_SHARE_ARBITER_CARRY_EN
  // Carry-out travels with the sum and obeys the same load rule.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_cout <= 1'b0;
    end else if (transfer) begin
      resp_cout <= sum_full[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed testbench for add_share_arbiter with hand-computed results.
// Optional feature: ADD_SHARE_ARBITER_CARRY_EN enables resp_cout checks.
module tb_add_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_sum;
`ifdef ADD_SHARE_ARBITER_CARRY_EN
  logic                  resp_cout;
`endif

  int vectors_applied;
  int miscompares;

  logic [31:0] exp_sum [NREQ];

  add_share_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum)
`ifdef ADD_SHARE_ARBITER_CARRY_EN
    ,
    .resp_cout  (resp_cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    vectors_applied++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
    req_valid  = valid;
    resp_ready = ready;
    #1;
  endtask

  task automatic setOperands(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst_n      = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_valid  = '0;
    resp_ready = 1'b0;

    // Operands chosen so every requester yields a distinct sum.
    setOperands(0, 32'h0000_0101, 32'h0000_0010);
    setOperands(1, 32'h0000_0201, 32'h0000_0011);
    setOperands(2, 32'h0000_0301, 32'h0000_0012);
    setOperands(3, 32'h0000_0401, 32'h0000_0013);
    exp_sum[0] = 32'h0000_0111;
    exp_sum[1] = 32'h0000_0212;
    exp_sum[2] = 32'h0000_0313;
    exp_sum[3] = 32'h0000_0414;

    // Reset held with all requesters valid.
    applyStimulus(4'hF, 1'b1);
    tick();
    tick();
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("reset_resp_sum", 64'(resp_sum), 64'h0);
    checkOutput("reset_resp_id", 64'(resp_id), 64'h0);
`ifdef ADD_SHARE_ARBITER_CARRY_EN
    checkOutput("reset_resp_cout", 64'(resp_cout), 64'h0);
`endif

    // Round robin: all valid, consumer always ready, one result per cycle.
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = k % NREQ;
      checkOutput($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(4'b0001 << w));
      tick();
      checkOutput($sformatf("rr_valid_%0d", k), 64'(resp_valid), 64'h1);
      checkOutput($sformatf("rr_id_%0d", k), 64'(resp_id), 64'(w));
      checkOutput($sformatf("rr_sum_%0d", k), 64'(resp_sum), 64'(exp_sum[w]));
    end

    // Idle drain: no requests, slot empties but keeps its last data.
    applyStimulus(4'h0, 1'b1);
    checkOutput("idle_req_ready", 64'(req_ready), 64'h0);
    tick();
    checkOutput("drain_valid", 64'(resp_valid), 64'h0);
    checkOutput("drain_id_hold", 64'(resp_id), 64'h1);
    checkOutput("drain_sum_hold", 64'(resp_sum), 64'h0000_0212);

    // Single requester 2: 5 + 10.
    setOperands(2, 32'h0000_0005, 32'h0000_000A);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_grant", 64'(req_ready), 64'h4);
    tick();
    checkOutput("single_valid", 64'(resp_valid), 64'h1);
    checkOutput("single_id", 64'(resp_id), 64'h2);
    checkOutput("single_sum", 64'(resp_sum), 64'h0000_000F);
`ifdef ADD_SHARE_ARBITER_CARRY_EN
    checkOutput("single_cout", 64'(resp_cout), 64'h0);
`endif

    // Backpressure: slot full, consumer stalled for three cycles.
    applyStimulus(4'hF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("stall_ready_%0d", k), 64'(req_ready), 64'h0);
      tick();
      checkOutput($sformatf("stall_valid_%0d", k), 64'(resp_valid), 64'h1);
      checkOutput($sformatf("stall_id_%0d", k), 64'(resp_id), 64'h2);
      checkOutput($sformatf("stall_sum_%0d", k), 64'(resp_sum), 64'h0000_000F);
    end
    // Release: drain and refill in the same cycle; pointer still at 3.
    applyStimulus(4'hF, 1'b1);
    checkOutput("release_grant", 64'(req_ready), 64'h8);
    tick();
    checkOutput("refill_valid", 64'(resp_valid), 64'h1);
    checkOutput("refill_id", 64'(resp_id), 64'h3);
    checkOutput("refill_sum", 64'(resp_sum), 64'h0000_0414);

    // Wrap: 0xFFFFFFFF + 1 drops the carry.
    setOperands(0, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("wrap_grant", 64'(req_ready), 64'h1);
    tick();
    checkOutput("wrap_valid", 64'(resp_valid), 64'h1);
    checkOutput("wrap_id", 64'(resp_id), 64'h0);
    checkOutput("wrap_sum", 64'(resp_sum), 64'h0);
`ifdef ADD_SHARE_ARBITER_CARRY_EN
    checkOutput("wrap_cout", 64'(resp_cout), 64'h1);
`endif

    // Reset while full and stalled; pointer is 1 at this point.
    applyStimulus(4'b1010, 1'b0);
    checkOutput("prereset_ready", 64'(req_ready), 64'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("inreset_ready", 64'(req_ready), 64'h0);
    tick();
    checkOutput("midreset_valid", 64'(resp_valid), 64'h0);
    checkOutput("midreset_sum", 64'(resp_sum), 64'h0);
    // Pointer must be back at 0: requester 0 beats requester 3.
    setOperands(0, 32'h0000_0007, 32'h0000_0008);
    rst_n = 1'b1;
    applyStimulus(4'b1001, 1'b1);
    checkOutput("postreset_grant", 64'(req_ready), 64'h1);
    tick();
    checkOutput("postreset_valid", 64'(resp_valid), 64'h1);
    checkOutput("postreset_id", 64'(resp_id), 64'h0);
    checkOutput("postreset_sum", 64'(resp_sum), 64'h0000_000F);
    // Next winner is requester 3 after the pointer advanced to 1.
    checkOutput("postreset_next_grant", 64'(req_ready), 64'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
